// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with strobe-gated h/v counters,
// registered sync/DE/coordinates, line/frame strobes and line prefetch.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PREFETCH = 8,
  parameter int CW       = 10,
  parameter int FCW      = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_pix_stb,
  input  logic           i_resync,
  output logic           o_hs,
  output logic           o_vs,
  output logic           o_de,
  output logic [CW-1:0]  o_x,
  output logic [CW-1:0]  o_y,
  output logic           o_line_start,
  output logic           o_frame_start,
  output logic           o_prefetch,
  output logic [CW-1:0]  o_prefetch_y,
  output logic [FCW-1:0] o_frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] PF_H   = CW'(H_TOTAL - PREFETCH);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_AM1  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  logic [CW-1:0] h, v;
  logic [CW-1:0] hd, vd;
  logic [CW-1:0] h_nxt, v_nxt;
  logic          hs_on, vs_on, de_n;
  logic          ls_n, fs_n, pf_n;
  logic          h_end, v_end;

  // Resync makes this strobe behave as if the raster were at (0,0).
  always_comb begin
    hd    = i_resync ? '0 : h;
    vd    = i_resync ? '0 : v;
    h_end = (hd == H_LAST);
    v_end = (vd == V_LAST);
    hs_on = (hd >= HS_BEG) && (hd < HS_END);
    vs_on = (vd >= VS_BEG) && (vd < VS_END);
    de_n  = (hd < H_ACT) && (vd < V_ACT);
    ls_n  = (hd == '0);
    fs_n  = ls_n && (vd == '0);
    pf_n  = (hd == PF_H) && (v_end || (vd < V_AM1));
    h_nxt = h_end ? '0 : hd + 1'b1;
    v_nxt = vd;
    if (h_end)
      v_nxt = v_end ? '0 : vd + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h             <= '0;
      v             <= '0;
      o_hs          <= ~HS_POL;
      o_vs          <= ~VS_POL;
      o_de          <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_prefetch    <= 1'b0;
      o_prefetch_y  <= '0;
      o_frame_cnt   <= '0;
    end else begin
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_prefetch    <= 1'b0;
      if (i_pix_stb) begin
        h             <= h_nxt;
        v             <= v_nxt;
        o_hs          <= hs_on ? HS_POL : ~HS_POL;
        o_vs          <= vs_on ? VS_POL : ~VS_POL;
        o_de          <= de_n;
        o_x           <= de_n ? hd : '0;
        o_y           <= (vd < V_ACT) ? vd : V_AM1;
        o_line_start  <= ls_n;
        o_frame_start <= fs_n;
        o_prefetch    <= pf_n;
        if (pf_n)
          o_prefetch_y <= v_end ? '0 : vd + 1'b1;
        if (fs_n)
          o_frame_cnt <= o_frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised scoreboard bench for video_timing_gen on a small raster,
// against a linear-position reference model.
module tb_video_timing_gen;

  localparam int HA = 6, HF = 2, HSW = 3, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 2, VB = 2;
  localparam bit HP = 1'b1, VP = 1'b0;
  localparam int PF = 5, CW = 5, FCW = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;

  typedef struct packed {
    logic           hs;
    logic           vs;
    logic           de;
    logic [CW-1:0]  x;
    logic [CW-1:0]  y;
    logic           ls;
    logic           fs;
    logic           pf;
    logic [CW-1:0]  pfy;
    logic [FCW-1:0] fc;
  } exp_t;

  logic           clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_pix_stb = 1'b0;
  logic           i_resync = 1'b0;
  logic           o_hs, o_vs, o_de;
  logic [CW-1:0]  o_x, o_y, o_prefetch_y;
  logic           o_line_start, o_frame_start, o_prefetch;
  logic [FCW-1:0] o_frame_cnt;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t cur;
  exp_t rst_val;
  int   p;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .PREFETCH(PF),
    .CW(CW), .FCW(FCW)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_pix_stb(i_pix_stb),
    .i_resync(i_resync),
    .o_hs(o_hs),
    .o_vs(o_vs),
    .o_de(o_de),
    .o_x(o_x),
    .o_y(o_y),
    .o_line_start(o_line_start),
    .o_frame_start(o_frame_start),
    .o_prefetch(o_prefetch),
    .o_prefetch_y(o_prefetch_y),
    .o_frame_cnt(o_frame_cnt)
  );

  function automatic exp_t act();
    exp_t a;
    a = '{o_hs, o_vs, o_de, o_x, o_y, o_line_start,
          o_frame_start, o_prefetch, o_prefetch_y, o_frame_cnt};
    return a;
  endfunction

  // Reference: raster position as one linear index into the frame.
  task automatic step(input bit rst, input bit stb, input bit rs);
    int h, v, nv;
    if (rst) begin
      p   = 0;
      cur = rst_val;
    end else begin
      cur.ls = 1'b0;
      cur.fs = 1'b0;
      cur.pf = 1'b0;
      if (stb) begin
        if (rs) p = 0;
        h = p % HT;
        v = p / HT;
        cur.hs = (h >= HA + HF && h < HA + HF + HSW) ? HP : !HP;
        cur.vs = (v >= VA + VF && v < VA + VF + VSW) ? VP : !VP;
        cur.de = (h < HA) && (v < VA);
        cur.x  = cur.de ? CW'(h) : '0;
        cur.y  = (v < VA) ? CW'(v) : CW'(VA - 1);
        cur.ls = (h == 0);
        cur.fs = (p == 0);
        if (cur.fs) cur.fc = cur.fc + 1'b1;
        nv = (v + 1) % VT;
        if (h == HT - PF && nv < VA) begin
          cur.pf  = 1'b1;
          cur.pfy = CW'(nv);
        end
        p = (p + 1) % (HT * VT);
      end
    end
    q.push_back(cur);
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = act();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL out cyc=%0d got=%h want=%h", cyc, a, e);
        end
      end
    end
  end

  initial begin : stim
    bit rst, stb, rs, prev_rst;
    exp_t a;
    rst_val = '{!HP, !VP, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0};
    cur = rst_val;
    p = 0;
    prev_rst = 1'b1;
    for (int c = 0; c < 4800; c++) begin
      @(negedge clk);
      cyc = c;
      rst = (c < 2);
      stb = 1'b0;
      rs  = 1'b0;
      if (c < 1000) begin
        stb = (c % 4 == 0);
        rs  = (c == 501) || (c == 700);
      end else if (c < 4000) begin
        stb = ($urandom % 2) == 1;
        rs  = ($urandom % 60) == 0;
        rst = ($urandom % 300) == 0;
      end else begin
        stb = 1'b1;
      end
      i_rst     = rst;
      i_pix_stb = stb;
      i_resync  = rs;
      if (rst && !prev_rst) begin
        #1;
        a = act();
        checks++;
        if (a !== rst_val) begin
          errors++;
          $display("FAIL async_rst cyc=%0d got=%h want=%h", c, a, rst_val);
        end
      end
      prev_rst = rst;
      step(rst, stb, rs);
    end
    @(negedge clk);
    i_pix_stb = 1'b0;
    i_resync  = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
